// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the indexed-sprite blit path.
//   Geometry of the sprite ROM and framebuffer, palette index width, the
//   transparent index, address widths and the blitter FSM state type.
package sprite_pkg;

  localparam int SPR_W  = 68;   // sprite width in pixels
  localparam int SPR_H  = 64;   // sprite height in pixels
  localparam int FB_W   = 320;  // framebuffer width in pixels
  localparam int FB_H   = 240;  // framebuffer height in pixels
  localparam int IDX_W  = 4;    // palette index width
  localparam int ROM_AW = 13;   // sprite ROM address width
  localparam int FB_AW  = 17;   // framebuffer address width

  localparam int SX_W   = $clog2(SPR_W);  // sprite column counter width
  localparam int SY_W   = $clog2(SPR_H);  // sprite row counter width
  localparam int POS_W  = 10;             // screen position input width
  localparam int CRD_W  = 11;             // screen coordinate width (no wrap)
  localparam int LIN_W  = FB_AW + 1;      // linear address scratch width

  typedef logic [IDX_W-1:0] pix_idx_t;

  localparam pix_idx_t TRANSP_IDX = '0;   // this index is never written

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter: raster counter over the sprite (sx fastest, then sy).
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   i_clear      force sx = sy = 0 (start of a new sprite)
//   i_enable     advance one pixel
//   i_flip       mirror the column output
//   o_sx, o_sy   current raster position
//   o_col        ROM column for this pixel (mirrored when i_flip)
//   o_last       current position is the final pixel of the sprite
module sprite_scan_counter
  import sprite_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            i_clear,
  input  logic            i_enable,
  input  logic            i_flip,
  output logic [SX_W-1:0] o_sx,
  output logic [SY_W-1:0] o_sy,
  output logic [SX_W-1:0] o_col,
  output logic            o_last
);

  logic [SX_W-1:0] r_sx;
  logic [SY_W-1:0] r_sy;
  logic            w_row_end;

  assign w_row_end = (r_sx == SX_W'(SPR_W - 1));

  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (i_enable) begin
      if (w_row_end) begin
        r_sx <= '0;
        // Row counter wraps after the last row so the counter idles at 0,0.
        r_sy <= (r_sy == SY_W'(SPR_H - 1)) ? '0 : r_sy + 1'b1;
      end else begin
        r_sx <= r_sx + 1'b1;
      end
    end
  end

  assign o_sx   = r_sx;
  assign o_sy   = r_sy;
  assign o_col  = i_flip ? (SX_W'(SPR_W - 1) - r_sx) : r_sx;
  assign o_last = w_row_end && (r_sy == SY_W'(SPR_H - 1));

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one sprite from the palette-index ROM into the
// indexed framebuffer at (pos_x, pos_y), skipping transparent pixels,
// clipping at the screen edge and optionally mirroring horizontally.
//
// Handshake: start is sampled only in IDLE; an accepted start latches
// pos_x/pos_y/flip_h. busy is high from the next cycle through the end of
// the pipeline drain; done then pulses for exactly one cycle with busy low.
// A start seen while busy or during done is dropped, not queued.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   start               blit request
//   pos_x, pos_y        top-left framebuffer position of the sprite
//   flip_h              mirror horizontally
//   busy, done          status
//   rom_address, rom_q  sprite ROM read port (1-cycle read latency)
//   fb_we, fb_addr,     framebuffer write port
//   fb_data
//   o_dbg_state         current FSM state
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [POS_W-1:0]   pos_x,
  input  logic [POS_W-1:0]   pos_y,
  input  logic               flip_h,
  output logic               busy,
  output logic               done,
  output logic [ROM_AW-1:0]  rom_address,
  input  pix_idx_t           rom_q,
  output logic               fb_we,
  output logic [FB_AW-1:0]   fb_addr,
  output pix_idx_t           fb_data,
  output blit_state_t        o_dbg_state
);

  blit_state_t      r_state;
  blit_state_t      w_next;
  logic [POS_W-1:0] r_pos_x;
  logic [POS_W-1:0] r_pos_y;
  logic             r_flip;
  logic             r_drain;

  logic             w_accept;
  logic             w_run;
  logic [SX_W-1:0]  w_sx;
  logic [SY_W-1:0]  w_sy;
  logic [SX_W-1:0]  w_col;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_run    = (r_state == RUN);

  sprite_scan_counter u_scan (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_clear  (w_accept),
    .i_enable (w_run),
    .i_flip   (r_flip),
    .o_sx     (w_sx),
    .o_sy     (w_sy),
    .o_col    (w_col),
    .o_last   (w_last)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_drain <= 1'b0;
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_flip  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Two-cycle drain: first DRAIN cycle sets the flag, second one exits.
      r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
      if (w_accept) begin
        r_pos_x <= pos_x;
        r_pos_y <= pos_y;
        r_flip  <= flip_h;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)   w_next = RUN;
      RUN:     if (w_last)  w_next = DRAIN;
      DRAIN:   if (r_drain) w_next = DONE;
      DONE:                 w_next = IDLE;
      default:              w_next = IDLE;
    endcase
  end

  assign busy        = (r_state == RUN) || (r_state == DRAIN);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;

  // ---------------- ROM read (issued combinationally from the counter) ----
  logic [ROM_AW-1:0] w_rom_addr;
  assign w_rom_addr  = ROM_AW'(w_sy) * ROM_AW'(SPR_W) + ROM_AW'(w_col);
  assign rom_address = w_run ? w_rom_addr : '0;

  // ---------------- Stage 1: screen coordinate and visibility -------------
  logic [CRD_W-1:0] w_fx;
  logic [CRD_W-1:0] w_fy;
  logic             w_vis;
  logic             r_s1_valid;
  logic [CRD_W-1:0] r_s1_fx;
  logic [CRD_W-1:0] r_s1_fy;
  logic             r_s1_vis;

  // Coordinates are wide enough that pos + offset never wraps, so anything
  // past the right/bottom edge (including fully off-screen) is simply clipped.
  assign w_fx  = CRD_W'(r_pos_x) + CRD_W'(w_sx);
  assign w_fy  = CRD_W'(r_pos_y) + CRD_W'(w_sy);
  assign w_vis = (w_fx < CRD_W'(FB_W)) && (w_fy < CRD_W'(FB_H));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_fx    <= '0;
      r_s1_fy    <= '0;
      r_s1_vis   <= 1'b0;
    end else begin
      r_s1_valid <= w_run;
      r_s1_fx    <= w_fx;
      r_s1_fy    <= w_fy;
      r_s1_vis   <= w_vis;
    end
  end

  // ---------------- Stage 2: framebuffer write (rom_q aligned here) -------
  logic [LIN_W-1:0] w_lin;
  logic             w_write;

  assign w_lin   = LIN_W'(r_s1_fy) * LIN_W'(FB_W) + LIN_W'(r_s1_fx);
  assign w_write = r_s1_valid && r_s1_vis && (rom_q != TRANSP_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= w_write;
      // Address/data hold between writes; the linear address always fits
      // FB_AW bits whenever the pixel is visible.
      if (w_write) begin
        fb_addr <= FB_AW'(w_lin);
        fb_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int DONE_CYC = SPR_W * SPR_H + 3;  // 4355
  localparam int BUSY_CYC = SPR_W * SPR_H + 2;  // 4354
  localparam int BUDGET   = 4400;

  // ---------------- clock / reset ----------------
  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic [POS_W-1:0]  pos_x = '0;
  logic [POS_W-1:0]  pos_y = '0;
  logic              flip_h = 1'b0;
  logic              busy;
  logic              done;
  logic [ROM_AW-1:0] rom_address;
  pix_idx_t          rom_q = '0;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  pix_idx_t          fb_data;
  blit_state_t       dbg_state;

  always #5 Clk = ~Clk;

  sprite_blitter dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_h      (flip_h),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .o_dbg_state (dbg_state)
  );

  // Sprite ROM model: index = address mod 16, one-cycle read latency.
  always @(posedge Clk) rom_q <= rom_address[IDX_W-1:0];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [FB_AW+IDX_W-1:0] exp_q[$];
  logic [FB_AW+IDX_W-1:0] mon_e;

  int n_writes;
  int exp_writes;
  int max_addr;
  int first_addr;
  int first_data;
  bit first_seen;
  int first_rom;
  int busy_cnt;
  int done_cnt;
  int done_cyc;
  int bad_after_reset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Write monitor: every framebuffer write is matched against the queue.
  always @(negedge Clk) begin
    if (fb_we === 1'b1) begin
      n_writes++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("fb_addr", 32'(fb_addr), 32'(mon_e[FB_AW+IDX_W-1:IDX_W]));
        check("fb_data", 32'(fb_data), 32'(mon_e[IDX_W-1:0]));
      end
      if (!first_seen) begin
        first_seen = 1'b1;
        first_addr = int'(fb_addr);
        first_data = int'(fb_data);
      end
      if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_blit(input int px, input int py, input bit fl,
                          input int restart_at, input bit start_in_done,
                          input int reset_at);
    exp_writes = 0;
    for (int y = 0; y < SPR_H; y++) begin
      for (int x = 0; x < SPR_W; x++) begin
        int fx, fy, ra, idx;
        fx  = px + x;
        fy  = py + y;
        ra  = y * SPR_W + (fl ? (SPR_W - 1 - x) : x);
        idx = ra % 16;
        if (fx < FB_W && fy < FB_H && idx != int'(TRANSP_IDX)) begin
          exp_q.push_back({FB_AW'(fy * FB_W + fx), IDX_W'(idx)});
          exp_writes++;
        end
      end
    end
    n_writes = 0; max_addr = -1; first_seen = 1'b0; first_addr = -1;
    first_data = -1; first_rom = -1; busy_cnt = 0; done_cnt = 0;
    done_cyc = -1; bad_after_reset = 0;

    pos_x  = 10'(px);
    pos_y  = 10'(py);
    flip_h = fl;
    start  = 1'b1;
    @(posedge Clk); #1;  // edge 0: start accepted
    start  = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      start = (k == restart_at);
      if (reset_at != 0 && k == reset_at) Reset = 1'b1;
      if (reset_at != 0 && k == reset_at + 1) begin
        Reset = 1'b0;
        exp_q.delete();
      end
      @(negedge Clk);
      if (k == 1) first_rom = int'(rom_address);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      if (reset_at != 0 && k == reset_at + 1) begin
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
      end
      if (reset_at != 0 && k > reset_at)
        if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad_after_reset++;
      if (start_in_done && done === 1'b1) start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      if (done_cyc == k) break;
    end

    if (reset_at == 0) begin
      check("done_cycle", 32'(done_cyc), 32'(DONE_CYC));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(BUSY_CYC));
      check("write_count", 32'(n_writes), 32'(exp_writes));
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    end else begin
      check("rst_no_done", 32'(done_cnt), 32'd0);
      check("rst_quiet_cycles", 32'(bad_after_reset), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_fb_we", 32'(fb_we), 32'd0);
    check("reset_fb_addr", 32'(fb_addr), 32'd0);
    check("reset_fb_data", 32'(fb_data), 32'd0);
    check("reset_rom_address", 32'(rom_address), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Blit at origin, with start pulses at cycle 100 and during DONE.
    run_blit(0, 0, 1'b0, 100, 1'b1, 0);
    check("origin_writes", 32'(n_writes), 32'd4080);
    check("origin_first_addr", 32'(first_addr), 32'd1);
    check("origin_first_data", 32'(first_data), 32'd1);

    // Back-to-back: start in the cycle right after done; clipped at corner.
    run_blit(300, 200, 1'b0, 0, 1'b0, 0);
    check("corner_writes", 32'(n_writes), 32'd750);
    check("corner_max_addr", 32'(max_addr), 32'd76799);

    // Horizontal flip at origin.
    run_blit(0, 0, 1'b1, 0, 1'b0, 0);
    check("flip_first_rom", 32'(first_rom), 32'd67);
    check("flip_first_addr", 32'(first_addr), 32'd0);
    check("flip_first_data", 32'(first_data), 32'd3);

    // Reset in the middle of a blit, then a normal blit.
    run_blit(10, 20, 1'b0, 0, 1'b0, 500);
    run_blit(5, 7, 1'b0, 0, 1'b0, 0);

    // Fully off-screen.
    run_blit(320, 0, 1'b0, 0, 1'b0, 0);
    check("offscreen_writes", 32'(n_writes), 32'd0);

    // Random position / flip.
    run_blit($urandom_range(0, 339), $urandom_range(0, 259),
             1'($urandom_range(0, 1)), 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
